// File: rtl/core_pkg.sv
// core_pkg: shared constants and types for the RV32I core front end.
//   XLEN         - datapath width
//   NOP_INST     - canonical NOP (addi x0, x0, 0) used as the IF/ID bubble
//   ECALL_INST   - system call encoding, stops fetch
//   EBREAK_INST  - breakpoint encoding, stops fetch
//   fetch_state_e - fetch sequencer states
//   is_halt_inst - true for ECALL/EBREAK
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INST    = 32'h0000_0013;
    localparam logic [XLEN-1:0] ECALL_INST  = 32'h0000_0073;
    localparam logic [XLEN-1:0] EBREAK_INST = 32'h0010_0073;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    function automatic logic is_halt_inst(input logic [XLEN-1:0] inst);
        return (inst == ECALL_INST) || (inst == EBREAK_INST);
    endfunction

endpackage

// File: rtl/bit_mux.sv
// bit_mux: 32-bit 2:1 multiplexer shared across the core.
//   w0 - selected when s = 0
//   w1 - selected when s = 1
//   s  - select
//   y  - result
module bit_mux (
    input  logic [31:0] w0,
    input  logic [31:0] w1,
    input  logic        s,
    output logic [31:0] y
);

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_bit
            assign y[gi] = s ? w1[gi] : w0[gi];
        end
    endgenerate

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage of the RV32I pipeline.
// Owns the PC, drives the instruction memory address and loads IF/ID.
//   clk, rst            - clock, asynchronous active-high reset
//   stall               - hold PC and IF/ID
//   branch_taken        - redirect from EX (also next-PC mux select)
//   branch_target       - redirect address (low two bits dropped)
//   imem_addr/imem_en   - instruction memory address and fetch enable
//   imem_rdata          - instruction at imem_addr, same cycle
//   ifid_pc/pc4/inst/valid - IF/ID pipeline register
//   halted              - fetch stopped by ECALL/EBREAK
//   misalign_err        - sticky: a misaligned branch target was taken
//   fetch_count         - number of valid instructions loaded into IF/ID
module if_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    output logic        imem_en,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_inst,
    output logic        ifid_valid,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    fetch_state_e state_reg, state_next;

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] target_aligned;
    logic [XLEN-1:0] pc_next;

    logic pc_load;
    logic ifid_load;
    logic ifid_flush;
    logic mis_set;

    assign pc_plus4       = pc_reg + 32'd4;
    assign target_aligned = {branch_target[31:2], 2'b00};

    // Stall/halt hold is handled by pc_load acting as a register enable;
    // the mux only chooses between sequential and redirected flow.
    bit_mux u_next_pc_mux (
        .w0 (pc_plus4),
        .w1 (target_aligned),
        .s  (branch_taken),
        .y  (pc_next)
    );

    always_comb begin
        state_next = state_reg;
        pc_load    = 1'b0;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        mis_set    = 1'b0;
        case (state_reg)
            BOOT: begin
                // One settling cycle: PC held, bubble in IF/ID.
                state_next = RUN;
                ifid_flush = 1'b1;
            end
            RUN: begin
                if (branch_taken) begin
                    pc_load    = 1'b1;
                    ifid_flush = 1'b1;
                    mis_set    = |branch_target[1:0];
                end else if (!stall) begin
                    pc_load   = 1'b1;
                    ifid_load = 1'b1;
                    if (is_halt_inst(imem_rdata)) begin
                        state_next = HALT;
                    end
                end
            end
            HALT: begin
                // A redirect arriving here came from an older branch, so the
                // halting instruction is squashed and fetch resumes.
                if (branch_taken) begin
                    pc_load    = 1'b1;
                    ifid_flush = 1'b1;
                    mis_set    = |branch_target[1:0];
                    state_next = RUN;
                end else if (!stall) begin
                    ifid_flush = 1'b1;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= BOOT;
            pc_reg       <= RESET_PC;
            ifid_pc      <= '0;
            ifid_pc4     <= '0;
            ifid_inst    <= NOP_INST;
            ifid_valid   <= 1'b0;
            misalign_err <= 1'b0;
            fetch_count  <= '0;
        end else begin
            state_reg <= state_next;
            if (pc_load) begin
                pc_reg <= pc_next;
            end
            if (ifid_load) begin
                ifid_pc     <= pc_reg;
                ifid_pc4    <= pc_plus4;
                ifid_inst   <= imem_rdata;
                ifid_valid  <= 1'b1;
                fetch_count <= fetch_count + 32'd1;
            end else if (ifid_flush) begin
                ifid_pc    <= '0;
                ifid_pc4   <= '0;
                ifid_inst  <= NOP_INST;
                ifid_valid <= 1'b0;
            end
            if (mis_set) begin
                misalign_err <= 1'b1;
            end
        end
    end

    assign imem_addr = pc_reg;
    assign imem_en   = (state_reg == RUN);
    assign halted    = (state_reg == HALT);

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed plus randomized check of if_stage against a
// behavioural fetch model (RESET_PC = 0x100).
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata = NOP;
    logic [31:0] ifid_pc, ifid_pc4, ifid_inst, fetch_count;
    logic        ifid_valid, halted, misalign_err;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit          m_booting;
    bit          m_halted;
    logic [31:0] m_pc, m_ipc, m_ipc4, m_inst, m_cnt;
    bit          m_valid, m_mis;

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_en       (imem_en),
        .imem_rdata    (imem_rdata),
        .ifid_pc       (ifid_pc),
        .ifid_pc4      (ifid_pc4),
        .ifid_inst     (ifid_inst),
        .ifid_valid    (ifid_valid),
        .halted        (halted),
        .misalign_err  (misalign_err),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_booting = 1;
        m_halted  = 0;
        m_pc      = RST_PC;
        m_ipc     = 0;
        m_ipc4    = 0;
        m_inst    = NOP;
        m_valid   = 0;
        m_mis     = 0;
        m_cnt     = 0;
    endtask

    task automatic model_bubble();
        m_ipc   = 0;
        m_ipc4  = 0;
        m_inst  = NOP;
        m_valid = 0;
    endtask

    // One rising edge of the fetch stage, described by what the stage does.
    task automatic model_edge(input bit st, input bit br, input logic [31:0] tgt,
                              input logic [31:0] rd);
        if (m_booting) begin
            m_booting = 0;
            model_bubble();
        end else if (br) begin
            m_pc = tgt & 32'hFFFF_FFFC;
            model_bubble();
            if (tgt % 4 != 0) m_mis = 1;
            m_halted = 0;
        end else if (m_halted) begin
            if (!st) model_bubble();
        end else if (!st) begin
            m_ipc   = m_pc;
            m_ipc4  = m_pc + 4;
            m_inst  = rd;
            m_valid = 1;
            m_cnt   = m_cnt + 1;
            m_pc    = m_pc + 4;
            if (rd == ECALL || rd == EBREAK) m_halted = 1;
        end
    endtask

    task automatic check_all(input string where);
        check({where, ".imem_addr"},    imem_addr,    m_pc);
        check({where, ".imem_en"},      {31'b0, imem_en}, {31'b0, !m_booting && !m_halted});
        check({where, ".ifid_pc"},      ifid_pc,      m_ipc);
        check({where, ".ifid_pc4"},     ifid_pc4,     m_ipc4);
        check({where, ".ifid_inst"},    ifid_inst,    m_inst);
        check({where, ".ifid_valid"},   {31'b0, ifid_valid},   {31'b0, m_valid});
        check({where, ".halted"},       {31'b0, halted},       {31'b0, m_halted});
        check({where, ".misalign_err"}, {31'b0, misalign_err}, {31'b0, m_mis});
        check({where, ".fetch_count"},  fetch_count,  m_cnt);
    endtask

    // Called at a falling edge: drive, clock once, check at next falling edge.
    task automatic step(input string tag, input bit st, input bit br,
                        input logic [31:0] tgt, input logic [31:0] rd);
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        imem_rdata    = rd;
        @(posedge clk);
        model_edge(st, br, tgt, rd);
        @(negedge clk);
        $display("%s: st=%0d br=%0d tgt=%h rd=%h -> pc=%h ifid=%h/%h v=%0d h=%0d cnt=%0d",
                 tag, st, br, tgt, rd, imem_addr, ifid_pc, ifid_inst, ifid_valid,
                 halted, fetch_count);
        check_all(tag);
    endtask

    // Asynchronous reset asserted mid-cycle, with the current inputs still applied.
    task automatic async_reset(input string tag);
        #2 rst = 1;
        #1;
        model_reset();
        $display("%s: async reset asserted, pc=%h", tag, imem_addr);
        check_all({tag, ".async"});
        @(negedge clk);
        rst = 0;
        check_all({tag, ".held"});
    endtask

    function automatic logic [31:0] rand_inst();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return ECALL;
        if (r == 1) return EBREAK;
        if (r < 5)  return NOP;
        return $urandom;
    endfunction

    initial begin
        model_reset();
        @(negedge clk);
        async_reset("init");

        // Bring-up stream of NOPs
        step("boot", 0, 0, 0, NOP);
        step("run1", 0, 0, 0, NOP);
        step("run2", 0, 0, 0, NOP);
        step("run3", 0, 0, 0, NOP);   // PC now 0x10C, ifid_pc 0x108
        // Stall for 3 cycles, then release
        for (int i = 0; i < 3; i++) step("stall", 1, 0, 0, 32'h1234_5678);
        step("resume", 0, 0, 0, NOP);
        // Branch wins over stall
        step("br_stall", 1, 1, 32'h40, NOP);
        step("after_br", 0, 0, 0, NOP);
        // Misaligned target
        step("br_mis", 0, 1, 32'h42, NOP);
        step("mis_keep", 0, 0, 0, NOP);
        // ECALL at 0x20 halts
        step("br20", 0, 1, 32'h20, NOP);
        step("ecall", 0, 0, 0, ECALL);
        step("halt_st", 1, 0, 0, NOP);
        step("halt_nop", 0, 0, 0, NOP);
        step("halt_br", 0, 1, 32'h80, NOP);
        // Branch and ECALL together: branch wins
        step("br_ecall", 0, 1, 32'h200, ECALL);
        // PC wrap
        step("br_top", 0, 1, 32'hFFFF_FFFC, NOP);
        step("wrap", 0, 0, 0, NOP);
        step("wrap2", 0, 0, 0, EBREAK);
        // Async reset during a branch
        stall = 1; branch_taken = 1; branch_target = 32'h300;
        async_reset("rst_mid_br");

        for (int i = 0; i < 1500; i++) begin
            bit          st, br;
            logic [31:0] tgt;
            st  = ($urandom_range(0, 4) == 0);
            br  = ($urandom_range(0, 6) == 0);
            tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
            if ($urandom_range(0, 99) == 0) begin
                stall = st; branch_taken = br; branch_target = tgt;
                async_reset("rnd_rst");
            end else begin
                step("rnd", st, br, tgt, rand_inst());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
